// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int MEM_LAT_MAX = 3;
  localparam int LAT_W       = 2;
  typedef logic [LAT_W-1:0] lat_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick (combinational) with a registered last-grant pointer.
// Pointer advances only when en is high and a request is present.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_vld,
  output logic       gnt_sel
);

  logic last;

  always_comb begin
    gnt_vld = |req;
    if (req == 2'b11) gnt_sel = ~last;
    else              gnt_sel = req[1] ? PORT_DBG : PORT_CPU;
  end

  // Reset pointer to the debug port so the CPU wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                last <= PORT_DBG;
    else if (en && gnt_vld)    last <= gnt_sel;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU port (0) and the debug/DMA port (1).
// One transaction at a time: IDLE -> ISSUE -> WAIT x MEM_LAT -> RESP; done pulses 2+MEM_LAT cycles after the grant cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  output logic              mem_cs,
  output logic              mem_r,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  lat_t              lat_cnt;
  logic              sel_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              gnt_vld;
  logic              gnt_sel;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              finish;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({m1_req, m0_req}),
    .en      (state == IDLE),
    .gnt_vld (gnt_vld),
    .gnt_sel (gnt_sel)
  );

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    win_we    = (gnt_sel == PORT_DBG) ? m1_we    : m0_we;
    win_addr  = (gnt_sel == PORT_DBG) ? m1_addr  : m0_addr;
    win_wdata = (gnt_sel == PORT_DBG) ? m1_wdata : m0_wdata;
    // Read data is sampled at the end of ISSUE (combinational memory) or of the last WAIT cycle.
    finish    = ((state == ISSUE) && (MEM_LAT == 0)) ||
                ((state == WAIT)  && (lat_cnt == lat_t'(1)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      sel_q    <= PORT_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_cs   <= 1'b0;
      mem_r    <= 1'b0;
      mem_w    <= 1'b0;
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      mem_cs  <= 1'b0;
      mem_r   <= 1'b0;
      mem_w   <= 1'b0;
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            sel_q   <= gnt_sel;
            we_q    <= win_we;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            mem_cs  <= 1'b1;
            mem_r   <= ~win_we;
            mem_w   <= win_we;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (MEM_LAT != 0) begin
            lat_cnt <= lat_t'(MEM_LAT);
            state   <= WAIT;
          end
        end
        WAIT:    lat_cnt <= lat_cnt - lat_t'(1);
        RESP:    state   <= IDLE;
        default: state   <= IDLE;
      endcase
      if (finish) begin
        state   <= RESP;
        m0_done <= (sel_q == PORT_CPU);
        m1_done <= (sel_q == PORT_DBG);
        if (!we_q) begin
          if (sel_q == PORT_DBG) m1_rdata <= mem_rdata;
          else                   m0_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
